perf_stats_csr: RTL and testbench

- Downstream consumer of the accelerator performance monitor.
- Captures each completed measurement (total/active/idle cycle counts, qualified by the monitor's one-cycle done pulse) and maintains run statistics: last, min, max, saturating accumulators and run count.
- Optionally keeps a history FIFO of recent runs.
- Exposes everything to software through a simple read-only CSR port with 1-cycle read latency.

---
 rtl/perf_stats_csr_if.sv | 34 +++
 rtl/perf_stats_csr.sv | 269 ++++++++++++++++++++++++++
 tb/tb_perf_stats_csr.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/perf_stats_csr_if.sv
// ============================================================================
// Module   : perf_stats_csr_if
// Brief    : Measurement input and CSR read bus for perf_stats_csr.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface perf_stats_csr_if #(
  parameter int COUNTER_WIDTH = 32,
  parameter int ADDR_WIDTH    = 4
);
  logic                     meas_valid;
  logic [COUNTER_WIDTH-1:0] total_in;
  logic [COUNTER_WIDTH-1:0] active_in;
  logic [COUNTER_WIDTH-1:0] idle_in;
  logic                     clr_pulse;
  logic                     csr_rd_en;
  logic [ADDR_WIDTH-1:0]    csr_addr;
  logic [COUNTER_WIDTH-1:0] csr_rdata;
  logic                     csr_rvalid;

  modport master (
    output meas_valid, total_in, active_in, idle_in, clr_pulse, csr_rd_en, csr_addr,
    input  csr_rdata, csr_rvalid
  );

  modport slave (
    input  meas_valid, total_in, active_in, idle_in, clr_pulse, csr_rd_en, csr_addr,
    output csr_rdata, csr_rvalid
  );
endinterface

`default_nettype wire

// File: rtl/perf_stats_csr.sv
// ============================================================================
// Module   : perf_stats_csr
// Brief    : Run statistics (last/min/max/saturating sums/count) behind a
//            read-only CSR port; history FIFO built when PERF_HIST_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module perf_stats_csr #(
  parameter int COUNTER_WIDTH = 32,
  parameter int HIST_DEPTH    = 8,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  perf_stats_csr_if.slave bus
);

  localparam logic [COUNTER_WIDTH-1:0] c_ONES = {COUNTER_WIDTH{1'b1}};

  localparam logic [ADDR_WIDTH-1:0] c_A_LAST_TOTAL  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] c_A_LAST_ACTIVE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_A_LAST_IDLE   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] c_A_RUN_COUNT   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] c_A_MIN_TOTAL   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] c_A_MAX_TOTAL   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] c_A_ACC_ACTIVE  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] c_A_ACC_TOTAL   = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] c_A_STATUS      = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] c_A_HIST_TOTAL  = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] c_A_HIST_ACTIVE = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] c_A_HIST_IDLE   = ADDR_WIDTH'(11);

  logic [COUNTER_WIDTH-1:0] r_last_total;
  logic [COUNTER_WIDTH-1:0] r_last_active;
  logic [COUNTER_WIDTH-1:0] r_last_idle;
  logic [COUNTER_WIDTH-1:0] r_run_count;
  logic [COUNTER_WIDTH-1:0] r_min_total;
  logic [COUNTER_WIDTH-1:0] r_max_total;
  logic [COUNTER_WIDTH-1:0] r_acc_active;
  logic [COUNTER_WIDTH-1:0] r_acc_total;
  logic                     r_acc_active_sat;
  logic                     r_acc_total_sat;
  logic                     r_run_sat;
  logic [COUNTER_WIDTH-1:0] r_rdata;
  logic                     r_rvalid;

  // History view shared by STATUS and the read mux, driven by either build
  logic                     w_hist_empty;
  logic                     w_hist_full;
  logic                     w_hist_ovf;
  logic [7:0]               w_hist_count8;
  logic [COUNTER_WIDTH-1:0] w_head_total;
  logic [COUNTER_WIDTH-1:0] w_head_active;
  logic [COUNTER_WIDTH-1:0] w_head_idle;

  // A coincident clear is folded in first, so the sample lands on reset values
  logic [COUNTER_WIDTH-1:0] w_base_run;
  logic [COUNTER_WIDTH-1:0] w_base_min;
  logic [COUNTER_WIDTH-1:0] w_base_max;
  logic [COUNTER_WIDTH-1:0] w_base_acc_active;
  logic [COUNTER_WIDTH-1:0] w_base_acc_total;
  logic                     w_base_run_sat;
  logic                     w_base_act_sat;
  logic                     w_base_tot_sat;
  logic [COUNTER_WIDTH:0]   w_run_sum;
  logic [COUNTER_WIDTH:0]   w_act_sum;
  logic [COUNTER_WIDTH:0]   w_tot_sum;

  assign w_base_run        = bus.clr_pulse ? '0     : r_run_count;
  assign w_base_min        = bus.clr_pulse ? c_ONES : r_min_total;
  assign w_base_max        = bus.clr_pulse ? '0     : r_max_total;
  assign w_base_acc_active = bus.clr_pulse ? '0     : r_acc_active;
  assign w_base_acc_total  = bus.clr_pulse ? '0     : r_acc_total;
  assign w_base_run_sat    = bus.clr_pulse ? 1'b0   : r_run_sat;
  assign w_base_act_sat    = bus.clr_pulse ? 1'b0   : r_acc_active_sat;
  assign w_base_tot_sat    = bus.clr_pulse ? 1'b0   : r_acc_total_sat;

  assign w_run_sum = {1'b0, w_base_run} + {{COUNTER_WIDTH{1'b0}}, 1'b1};
  assign w_act_sum = {1'b0, w_base_acc_active} + {1'b0, bus.active_in};
  assign w_tot_sum = {1'b0, w_base_acc_total} + {1'b0, bus.total_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_total     <= '0;
      r_last_active    <= '0;
      r_last_idle      <= '0;
      r_run_count      <= '0;
      r_min_total      <= c_ONES;
      r_max_total      <= '0;
      r_acc_active     <= '0;
      r_acc_total      <= '0;
      r_acc_active_sat <= 1'b0;
      r_acc_total_sat  <= 1'b0;
      r_run_sat        <= 1'b0;
    end else if (bus.meas_valid) begin
      r_last_total     <= bus.total_in;
      r_last_active    <= bus.active_in;
      r_last_idle      <= bus.idle_in;
      r_run_count      <= w_run_sum[COUNTER_WIDTH] ? c_ONES : w_run_sum[COUNTER_WIDTH-1:0];
      r_run_sat        <= w_base_run_sat | w_run_sum[COUNTER_WIDTH];
      r_min_total      <= (bus.total_in < w_base_min) ? bus.total_in : w_base_min;
      r_max_total      <= (bus.total_in > w_base_max) ? bus.total_in : w_base_max;
      r_acc_active     <= w_act_sum[COUNTER_WIDTH] ? c_ONES : w_act_sum[COUNTER_WIDTH-1:0];
      r_acc_active_sat <= w_base_act_sat | w_act_sum[COUNTER_WIDTH];
      r_acc_total      <= w_tot_sum[COUNTER_WIDTH] ? c_ONES : w_tot_sum[COUNTER_WIDTH-1:0];
      r_acc_total_sat  <= w_base_tot_sat | w_tot_sum[COUNTER_WIDTH];
    end else if (bus.clr_pulse) begin
      r_last_total     <= '0;
      r_last_active    <= '0;
      r_last_idle      <= '0;
      r_run_count      <= '0;
      r_min_total      <= c_ONES;
      r_max_total      <= '0;
      r_acc_active     <= '0;
      r_acc_total      <= '0;
      r_acc_active_sat <= 1'b0;
      r_acc_total_sat  <= 1'b0;
      r_run_sat        <= 1'b0;
    end
  end

`ifdef PERF_HIST_EN
  localparam int c_PTR_W = $clog2(HIST_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(HIST_DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

  logic [COUNTER_WIDTH-1:0] r_mem_total  [HIST_DEPTH];
  logic [COUNTER_WIDTH-1:0] r_mem_active [HIST_DEPTH];
  logic [COUNTER_WIDTH-1:0] r_mem_idle   [HIST_DEPTH];
  logic [c_PTR_W-1:0]       r_head;
  logic [c_PTR_W-1:0]       r_tail;
  logic [c_CNT_W-1:0]       r_count;
  logic                     r_hist_ovf;
  logic [c_PTR_W-1:0]       w_nxt_head;
  logic [c_PTR_W-1:0]       w_nxt_tail;
  logic [c_PTR_W-1:0]       w_wr_ptr;
  logic [c_CNT_W-1:0]       w_nxt_count;
  logic                     w_nxt_ovf;
  logic                     w_pop;

  assign w_hist_empty  = (r_count == '0);
  assign w_hist_full   = (r_count == c_DEPTH_CNT);
  assign w_hist_ovf    = r_hist_ovf;
  assign w_hist_count8 = 8'(r_count);
  assign w_pop         = bus.csr_rd_en && (bus.csr_addr == c_A_HIST_TOTAL) && !w_hist_empty;
  assign w_head_total  = w_hist_empty ? '0 : r_mem_total[r_head];
  assign w_head_active = w_hist_empty ? '0 : r_mem_active[r_head];
  assign w_head_idle   = w_hist_empty ? '0 : r_mem_idle[r_head];

  always_comb begin
    w_nxt_head  = r_head;
    w_nxt_tail  = r_tail;
    w_nxt_count = r_count;
    w_nxt_ovf   = r_hist_ovf;
    w_wr_ptr    = r_tail;
    if (bus.clr_pulse) begin
      w_nxt_head  = '0;
      w_nxt_tail  = '0;
      w_nxt_count = '0;
      w_nxt_ovf   = 1'b0;
      w_wr_ptr    = '0;
      if (bus.meas_valid) begin
        w_nxt_tail  = c_PTR_ONE;
        w_nxt_count = c_CNT_ONE;
      end
    end else if (bus.meas_valid && w_pop) begin
      // Pop frees the head slot, so a push into a full FIFO never overflows here
      w_nxt_head = r_head + c_PTR_ONE;
      w_nxt_tail = r_tail + c_PTR_ONE;
    end else if (bus.meas_valid) begin
      w_nxt_tail = r_tail + c_PTR_ONE;
      if (w_hist_full) begin
        w_nxt_head = r_head + c_PTR_ONE;
        w_nxt_ovf  = 1'b1;
      end else begin
        w_nxt_count = r_count + c_CNT_ONE;
      end
    end else if (w_pop) begin
      w_nxt_head  = r_head + c_PTR_ONE;
      w_nxt_count = r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_hist_ovf <= 1'b0;
    end else begin
      r_head     <= w_nxt_head;
      r_tail     <= w_nxt_tail;
      r_count    <= w_nxt_count;
      r_hist_ovf <= w_nxt_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.meas_valid) begin
      r_mem_total[w_wr_ptr]  <= bus.total_in;
      r_mem_active[w_wr_ptr] <= bus.active_in;
      r_mem_idle[w_wr_ptr]   <= bus.idle_in;
    end
  end
`else
  assign w_hist_empty  = 1'b1;
  assign w_hist_full   = 1'b0;
  assign w_hist_ovf    = 1'b0;
  assign w_hist_count8 = 8'd0;
  assign w_head_total  = '0;
  assign w_head_active = '0;
  assign w_head_idle   = '0;
`endif

  logic [COUNTER_WIDTH-1:0] w_status;
  logic [COUNTER_WIDTH-1:0] w_rd_mux;

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_hist_empty;
    w_status[1]    = w_hist_full;
    w_status[2]    = w_hist_ovf;
    w_status[3]    = r_acc_active_sat;
    w_status[4]    = r_acc_total_sat;
    w_status[5]    = r_run_sat;
    w_status[15:8] = w_hist_count8;
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.csr_addr)
      c_A_LAST_TOTAL:  w_rd_mux = r_last_total;
      c_A_LAST_ACTIVE: w_rd_mux = r_last_active;
      c_A_LAST_IDLE:   w_rd_mux = r_last_idle;
      c_A_RUN_COUNT:   w_rd_mux = r_run_count;
      c_A_MIN_TOTAL:   w_rd_mux = r_min_total;
      c_A_MAX_TOTAL:   w_rd_mux = r_max_total;
      c_A_ACC_ACTIVE:  w_rd_mux = r_acc_active;
      c_A_ACC_TOTAL:   w_rd_mux = r_acc_total;
      c_A_STATUS:      w_rd_mux = w_status;
      c_A_HIST_TOTAL:  w_rd_mux = w_head_total;
      c_A_HIST_ACTIVE: w_rd_mux = w_head_active;
      c_A_HIST_IDLE:   w_rd_mux = w_head_idle;
      default:         w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= bus.csr_rd_en;
      if (bus.csr_rd_en) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.csr_rdata  = r_rdata;
  assign bus.csr_rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_perf_stats_csr.sv
// ============================================================================
// Module   : tb_perf_stats_csr
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a queue-based statistics model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_perf_stats_csr;

  localparam int W     = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
`ifdef PERF_HIST_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk;
  logic rst_n;

  perf_stats_csr_if #(.COUNTER_WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  perf_stats_csr #(.COUNTER_WIDTH(W), .HIST_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: statistics as plain values, history as a queue
  typedef struct packed {
    logic [W-1:0] t;
    logic [W-1:0] a;
    logic [W-1:0] i;
  } ent_t;

  ent_t         hq[$];
  logic [W-1:0] m_last_t, m_last_a, m_last_i, m_runs, m_min, m_max, m_acc_a, m_acc_t;
  bit           m_sat_a, m_sat_t, m_sat_run, m_ovf;
  bit           exp_rvalid = 1'b0;
  logic [W-1:0] exp_rdata  = '0;

  function automatic void m_clear();
    hq.delete();
    m_last_t = 0; m_last_a = 0; m_last_i = 0;
    m_runs = 0; m_min = ONES; m_max = 0; m_acc_a = 0; m_acc_t = 0;
    m_sat_a = 0; m_sat_t = 0; m_sat_run = 0; m_ovf = 0;
  endfunction

  function automatic logic [W-1:0] m_read(input logic [AW-1:0] addr);
    logic [W-1:0] st;
    st = 0;
    st[0]    = (hq.size() == 0);
    st[1]    = (hq.size() == DEPTH);
    st[2]    = m_ovf;
    st[3]    = m_sat_a;
    st[4]    = m_sat_t;
    st[5]    = m_sat_run;
    st[15:8] = 8'(hq.size());
    case (addr)
      4'd0:  return m_last_t;
      4'd1:  return m_last_a;
      4'd2:  return m_last_i;
      4'd3:  return m_runs;
      4'd4:  return m_min;
      4'd5:  return m_max;
      4'd6:  return m_acc_a;
      4'd7:  return m_acc_t;
      4'd8:  return st;
      4'd9:  return (hq.size() > 0) ? hq[0].t : '0;
      4'd10: return (hq.size() > 0) ? hq[0].a : '0;
      4'd11: return (hq.size() > 0) ? hq[0].i : '0;
      default: return '0;
    endcase
  endfunction

  function automatic void m_update(input bit mv, input logic [W-1:0] t, input logic [W-1:0] a,
                                   input logic [W-1:0] i, input bit clr, input bit rd,
                                   input logic [AW-1:0] addr);
    longint unsigned s;
    ent_t e;
    if (rd && addr == 4'd9 && hq.size() > 0) void'(hq.pop_front());
    if (clr) m_clear();
    if (mv) begin
      m_last_t = t; m_last_a = a; m_last_i = i;
      if (m_runs == ONES) m_sat_run = 1; else m_runs = m_runs + 1;
      if (t < m_min) m_min = t;
      if (t > m_max) m_max = t;
      s = longint'(m_acc_a) + longint'(a);
      if (s > longint'(ONES)) begin m_acc_a = ONES; m_sat_a = 1; end else m_acc_a = W'(s);
      s = longint'(m_acc_t) + longint'(t);
      if (s > longint'(ONES)) begin m_acc_t = ONES; m_sat_t = 1; end else m_acc_t = W'(s);
      if (HIST_EN) begin
        e.t = t; e.a = a; e.i = i;
        hq.push_back(e);
        if (hq.size() > DEPTH) begin
          void'(hq.pop_front());
          m_ovf = 1;
        end
      end
    end
  endfunction

  // One clock of stimulus; the model sees exactly what the DUT samples at the edge
  task automatic step(input bit mv, input logic [W-1:0] t, input logic [W-1:0] a,
                      input logic [W-1:0] i, input bit clr, input bit rd,
                      input logic [AW-1:0] addr);
    logic [W-1:0] rv;
    bus.meas_valid = mv;
    bus.total_in   = t;
    bus.active_in  = a;
    bus.idle_in    = i;
    bus.clr_pulse  = clr;
    bus.csr_rd_en  = rd;
    bus.csr_addr   = addr;
    rv = m_read(addr);
    m_update(mv, t, a, i, clr, rd, addr);
    @(posedge clk);
    #1;
    exp_rvalid = rd;
    if (rd) exp_rdata = rv;
    bus.meas_valid = 1'b0;
    bus.clr_pulse  = 1'b0;
    bus.csr_rd_en  = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] t, input logic [W-1:0] a, input logic [W-1:0] i);
    step(1'b1, t, a, i, 1'b0, 1'b0, '0);
  endtask

  task automatic clear();
    step(1'b0, '0, '0, '0, 1'b1, 1'b0, '0);
  endtask

  task automatic rd_lit(input logic [AW-1:0] addr, input logic [W-1:0] lit, input string name);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, addr);
    chk(name, bus.csr_rdata, lit);
  endtask

  // Continuous compare of the read port against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rvalid", {31'b0, bus.csr_rvalid}, {31'b0, exp_rvalid});
      if (exp_rvalid) chk("rdata", bus.csr_rdata, exp_rdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus.meas_valid = 1'b0;
    bus.total_in   = '0;
    bus.active_in  = '0;
    bus.idle_in    = '0;
    bus.clr_pulse  = 1'b0;
    bus.csr_rd_en  = 1'b0;
    bus.csr_addr   = '0;
    m_clear();
    repeat (3) @(posedge clk);
    #2;
    chk("reset_rdata", bus.csr_rdata, '0);
    chk("reset_rvalid", {31'b0, bus.csr_rvalid}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset values and the one-cycle rvalid pulse
    rd_lit(4'd4, 32'hFFFF_FFFF, "reset_min");
    chk("rvalid_pulse", {31'b0, bus.csr_rvalid}, 32'd1);
    rd_lit(4'd3, 32'd0, "reset_runs");
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("rvalid_drop", {31'b0, bus.csr_rvalid}, 32'd0);

    // Three back-to-back runs
    run(100, 60, 40);
    run(50, 50, 0);
    run(200, 10, 190);
    rd_lit(4'd0, 200, "last_total");
    rd_lit(4'd3, 3, "run_count");
    rd_lit(4'd4, 50, "min_total");
    rd_lit(4'd5, 200, "max_total");
    rd_lit(4'd6, 120, "acc_active");
    rd_lit(4'd7, 350, "acc_total");

    // Accumulator saturation then clear
    clear();
    run(32'hFFFF_FFF0, 0, 0);
    run(32'h20, 0, 0);
    rd_lit(4'd7, 32'hFFFF_FFFF, "acc_total_sat");
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd8);
    chk("status_tot_sat", {31'b0, bus.csr_rdata[4]}, 32'd1);
    clear();
    rd_lit(4'd8, 32'h1, "status_after_clr");
    rd_lit(4'd4, 32'hFFFF_FFFF, "min_after_clr");

    for (int k = 1; k <= 10; k++) run(k, k + 100, k + 200);
`ifdef PERF_HIST_EN
    rd_lit(4'd8, 32'h806, "status_full_ovf");
    rd_lit(4'd10, 103, "hist_peek_active");
    rd_lit(4'd11, 203, "hist_peek_idle");
    for (int k = 3; k <= 10; k++) rd_lit(4'd9, k, "hist_pop");
    rd_lit(4'd9, 0, "hist_pop_empty");
    rd_lit(4'd8, 32'h5, "status_empty_ovf");

    clear();
    for (int k = 11; k <= 18; k++) run(k, 0, 0);
    step(1'b1, 99, 0, 0, 1'b0, 1'b1, 4'd9);
    chk("pop_push_full", bus.csr_rdata, 11);
    rd_lit(4'd8, 32'h802, "status_pop_push_full");
`else
    rd_lit(4'd9, 0, "hist_total_off");
    rd_lit(4'd10, 0, "hist_active_off");
    rd_lit(4'd8, 32'h1, "status_hist_off");
`endif

    // Clear coincident with a sample
    step(1'b1, 77, 7, 70, 1'b1, 1'b0, '0);
    rd_lit(4'd3, 1, "clr_mv_runs");
    rd_lit(4'd4, 77, "clr_mv_min");
    rd_lit(4'd5, 77, "clr_mv_max");
    rd_lit(4'd8, HIST_EN ? 32'h100 : 32'h1, "clr_mv_status");

    // Read alongside a clear returns the pre-clear value
    step(1'b0, '0, '0, '0, 1'b1, 1'b1, 4'd0);
    chk("read_during_clr", bus.csr_rdata, 77);
    rd_lit(4'd0, 0, "after_clr_last");

    // Random traffic checked by the compare process
    for (int k = 0; k < 3000; k++) begin
      bit           mv, clr, rd;
      logic [W-1:0] t, a, i;
      logic [AW-1:0] addr;
      mv   = ($urandom_range(0, 1) == 1);
      clr  = ($urandom_range(0, 49) == 0);
      rd   = ($urandom_range(0, 9) < 6);
      t    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 1000));
      a    = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 1000));
      i    = W'($urandom_range(0, 1000));
      addr = ($urandom_range(0, 2) == 0) ? AW'(9) : AW'($urandom_range(0, 15));
      step(mv, t, a, i, clr, rd, addr);
    end

    // Asynchronous reset between edges
    run(5, 5, 5);
    rd_lit(4'd0, 5, "pre_async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_rdata", bus.csr_rdata, '0);
    chk("async_reset_rvalid", {31'b0, bus.csr_rvalid}, '0);
    m_clear();
    exp_rvalid = 1'b0;
    exp_rdata  = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd_lit(4'd4, 32'hFFFF_FFFF, "post_async_min");
    rd_lit(4'd8, 32'h1, "post_async_status");

    step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
